// File: rtl/word_loader.sv
// Packs a byte stream into the encoder's input SRAM: one 0x00-terminated word per
// run of non-separator bytes, followed by a single 0x00 end-of-list marker.
module word_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  overflow
);

    typedef enum logic [2:0] {IDLE, LOAD, TERM, ENDM, DONE} state_t;

    // Highest address a character may occupy; keeps room for a terminator and the end marker.
    localparam logic [ADDR_WIDTH-1:0] CHAR_LIMIT = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 3);
    localparam logic [DATA_WIDTH-1:0] SEP_SPACE  = DATA_WIDTH'(8'h20);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic                  in_word_q, in_word_d;
    logic [ADDR_WIDTH-1:0] word_count_q, word_count_d;
    logic                  overflow_q, overflow_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  done_q, done_d;
    logic                  is_sep;

    assign is_sep = (in_data == SEP_SPACE) || (in_data == '0);

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        in_word_d    = in_word_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    wp_d         = '0;
                    in_word_d    = 1'b0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (!is_sep) begin
                        if (wp_q <= CHAR_LIMIT) begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = wp_q;
                            mem_din_d  = in_data;
                            wp_d       = wp_q + 1'b1;
                            in_word_d  = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (in_word_q) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = wp_q;
                        mem_din_d    = '0;
                        wp_d         = wp_q + 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        in_word_d    = 1'b0;
                    end
                    if (in_last) begin
                        state_d = TERM;
                    end
                end
            end
            TERM: begin
                // Close a word that ran up to the end of the stream without a separator.
                if (in_word_q) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = wp_q;
                    mem_din_d    = '0;
                    wp_d         = wp_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    in_word_d    = 1'b0;
                end
                state_d = ENDM;
            end
            ENDM: begin
                mem_we_d   = 1'b1;
                mem_addr_d = wp_q;
                mem_din_d  = '0;
                state_d    = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            in_word_q    <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            in_word_q    <= in_word_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign done       = done_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_word_loader.sv
// Randomized and directed bench for word_loader: an SRAM shadow captures every write and
// is compared with an image built word-by-word from the byte stream.
module tb_word_loader;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;
    logic          overflow;

    word_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM shadow and event counters, sampled mid-cycle
    logic [7:0] tbmem [DEPTH];
    int         nwrites = 0;
    int         ndone   = 0;
    logic       clr_req = 1'b0;

    always @(negedge clk) begin
        if (clr_req) begin
            for (int a = 0; a < DEPTH; a++) tbmem[a] <= 8'hEE;
        end else if (mem_we) begin
            tbmem[mem_addr] <= mem_din;
        end
        if (mem_we) nwrites <= nwrites + 1;
        if (done) ndone <= ndone + 1;
    end

    // Reference model: split stream into words, then lay them out under the space rule
    logic [7:0] stim_q [$];
    logic [7:0] cur_word [$];
    logic [7:0] exp_img [DEPTH];
    int         m_pos, exp_wc, exp_nw;
    logic       exp_ovf;

    task automatic emit_word();
        int kept = 0;
        foreach (cur_word[j]) begin
            if (m_pos <= DEPTH - 3) begin
                exp_img[m_pos] = cur_word[j];
                m_pos++;
                kept++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (kept > 0) begin
            exp_img[m_pos] = 8'h00;
            m_pos++;
            exp_wc++;
        end
        cur_word.delete();
    endtask

    task automatic build_model();
        for (int a = 0; a < DEPTH; a++) exp_img[a] = 8'hEE;
        m_pos   = 0;
        exp_wc  = 0;
        exp_ovf = 1'b0;
        cur_word.delete();
        foreach (stim_q[i]) begin
            if (stim_q[i] == 8'h20 || stim_q[i] == 8'h00) emit_word();
            else cur_word.push_back(stim_q[i]);
        end
        emit_word();
        exp_img[m_pos] = 8'h00;
        exp_nw = m_pos + 1;
    endtask

    task automatic load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic run_load(input string name, input int max_gap, input bit hold_start);
        int nw0, nd0, notready, k;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        build_model();
        nw0 = nwrites;
        nd0 = ndone;
        notready = 0;
        start = 1'b1;
        @(negedge clk);
        start = hold_start;
        foreach (stim_q[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = (i == stim_q.size() - 1);
            if (in_ready !== 1'b1) notready++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        check({name, ".ready"}, 32'(notready), 32'd0);
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, ".done_lat"}, 32'(k), 32'd4);
        repeat (2) @(negedge clk);
        check({name, ".done_pulses"}, 32'(ndone - nd0), 32'd1);
        check({name, ".writes"}, 32'(nwrites - nw0), 32'(exp_nw));
        for (int a = 0; a < DEPTH; a++)
            check($sformatf("%s.mem[%0d]", name, a), 32'(tbmem[a]), 32'(exp_img[a]));
        check({name, ".word_count"}, 32'(word_count), 32'(exp_wc));
        check({name, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.word_count", 32'(word_count), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_str("hi yo");                       run_load("hi_yo", 0, 1'b0);
        load_str("  a  ");                       run_load("sp_a_sp", 0, 1'b0);
        load_str(" ");                           run_load("lone_sep", 0, 1'b0);
        load_str({20{"a"}});                     run_load("twenty_a", 0, 1'b0);
        load_str("ab cd");                       run_load("ab_cd_gaps", 3, 1'b0);
        load_str("ab cd");                       run_load("start_held", 1, 1'b1);

        // Reset in the middle of a load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h61 + 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        @(negedge clk);
        check("midrst.mem_we", 32'(mem_we), 32'd0);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(24, 1);
            stim_q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(5, 0))
                    0:       stim_q.push_back(8'h20);
                    1:       stim_q.push_back(8'h00);
                    2:       stim_q.push_back(8'h62);
                    default: stim_q.push_back(8'h61 + 8'($urandom_range(25, 0)));
                endcase
            end
            run_load($sformatf("rnd%0d", t), $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
